// File: rtl/ft232r_cmd_bridge.sv
// Byte-stream command decoder behind an FT232R UART: parses W/R commands into 16-bit
// register bus accesses and streams read data back. Define FT232R_CMD_BRIDGE_WR_ACK_EN to ACK writes.
module ft232r_cmd_bridge #(
  parameter int         P_RD_LATENCY     = 2,
  parameter int         P_TIMEOUT_CYCLES = 1_250_000,
  parameter logic [7:0] P_OP_WR          = 8'h57,
  parameter logic [7:0] P_OP_RD          = 8'h52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_req,
  output logic        cmd_ack,
  input  logic [7:0]  cmd_data,
  output logic        rsp_req,
  input  logic        rsp_ack,
  output logic [7:0]  rsp_data,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [15:0] reg_rdata,
  output logic        cmd_err
);

  localparam int             TW      = $clog2(P_TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TO_MAX  = TW'(P_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAT_MAX = 4'(P_RD_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L,
    S_WRITE, S_READ, S_RD_WAIT, S_TX_H, S_TX_L, S_TX_GAP
  } state_t;

  state_t        state_r;
  logic [TW-1:0] to_cnt_r;
  logic [3:0]    lat_cnt_r;
  logic [7:0]    hold_lo_r;
  logic          is_wr_r;
  logic          tx_last_r;

  logic rx_state;
  logic timed_state;
  logic accept;
  logic to_hit;

  // Byte acceptance and inter-byte timeout qualification.
  always_comb begin
    rx_state    = 1'b0;
    timed_state = 1'b0;
    case (state_r)
      S_IDLE:                                  rx_state = 1'b1;
      S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L: begin
        rx_state    = 1'b1;
        timed_state = 1'b1;
      end
      default: begin
        rx_state    = 1'b0;
        timed_state = 1'b0;
      end
    endcase
    accept = rx_state & cmd_req & ~cmd_ack;
    to_hit = timed_state & ~accept & (to_cnt_r == TO_MAX);
  end

  // Command FSM with registered handshake, bus and response outputs.
  // The high read byte lives directly in rsp_data, the low byte in hold_lo_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      to_cnt_r  <= '0;
      lat_cnt_r <= 4'd0;
      hold_lo_r <= 8'h00;
      is_wr_r   <= 1'b0;
      tx_last_r <= 1'b0;
      cmd_ack   <= 1'b0;
      rsp_req   <= 1'b0;
      rsp_data  <= 8'h00;
      reg_addr  <= 16'h0000;
      reg_wdata <= 16'h0000;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      cmd_err <= 1'b0;

      if (!cmd_req) begin
        cmd_ack <= 1'b0;
      end else if (accept) begin
        cmd_ack <= 1'b1;
      end else begin
        cmd_ack <= cmd_ack;
      end

      if (!timed_state || accept || to_hit) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end

      if (to_hit) begin
        state_r <= S_IDLE;
        cmd_err <= 1'b1;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (accept) begin
              if (cmd_data == P_OP_WR) begin
                is_wr_r <= 1'b1;
                state_r <= S_ADDR_H;
              end else if (cmd_data == P_OP_RD) begin
                is_wr_r <= 1'b0;
                state_r <= S_ADDR_H;
              end else begin
                cmd_err <= 1'b1;
              end
            end
          end
          S_ADDR_H: begin
            if (accept) begin
              reg_addr[15:8] <= cmd_data;
              state_r        <= S_ADDR_L;
            end
          end
          S_ADDR_L: begin
            if (accept) begin
              reg_addr[7:0] <= cmd_data;
              if (is_wr_r) begin
                state_r <= S_DATA_H;
              end else begin
                reg_rd  <= 1'b1;
                state_r <= S_READ;
              end
            end
          end
          S_DATA_H: begin
            if (accept) begin
              reg_wdata[15:8] <= cmd_data;
              state_r         <= S_DATA_L;
            end
          end
          S_DATA_L: begin
            if (accept) begin
              reg_wdata[7:0] <= cmd_data;
              reg_wr         <= 1'b1;
              state_r        <= S_WRITE;
            end
          end
          S_WRITE: begin
`ifdef FT232R_CMD_BRIDGE_WR_ACK_EN
            hold_lo_r <= 8'h06;
            rsp_data  <= 8'h06;
            rsp_req   <= 1'b1;
            state_r   <= S_TX_L;
`else
            state_r   <= S_IDLE;
`endif
          end
          S_READ: begin
            lat_cnt_r <= 4'd0;
            state_r   <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (lat_cnt_r == LAT_MAX) begin
              rsp_data  <= reg_rdata[15:8];
              hold_lo_r <= reg_rdata[7:0];
              rsp_req   <= 1'b1;
              state_r   <= S_TX_H;
            end else begin
              lat_cnt_r <= lat_cnt_r + 4'd1;
            end
          end
          S_TX_H, S_TX_L: begin
            if (rsp_ack) begin
              rsp_req   <= 1'b0;
              tx_last_r <= (state_r == S_TX_L);
              state_r   <= S_TX_GAP;
            end
          end
          S_TX_GAP: begin
            if (!rsp_ack) begin
              if (tx_last_r) begin
                state_r <= S_IDLE;
              end else begin
                rsp_data <= hold_lo_r;
                rsp_req  <= 1'b1;
                state_r  <= S_TX_L;
              end
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ft232r_cmd_bridge.sv
// Directed self-checking bench for ft232r_cmd_bridge (timeout shortened to 100 cycles).
module tb_ft232r_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_req = 1'b0;
  logic        cmd_ack;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_req;
  logic        rsp_ack = 1'b0;
  logic [7:0]  rsp_data;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_cnt = 0;
  logic [15:0] wr_addr = 16'h0, wr_data = 16'h0, rd_addr = 16'h0;
  logic        rsp_req_prev = 1'b0;
  logic [15:0] rd_value = 16'h0;
  logic        p1 = 1'b0, p2 = 1'b0;

  ft232r_cmd_bridge #(
    .P_RD_LATENCY    (2),
    .P_TIMEOUT_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_req  (cmd_req),
    .cmd_ack  (cmd_ack),
    .cmd_data (cmd_data),
    .rsp_req  (rsp_req),
    .rsp_ack  (rsp_ack),
    .rsp_data (rsp_data),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr   (reg_wr),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  // Register slave: data valid only in the cycle exactly two cycles after reg_rd.
  always @(posedge clk) begin
    p1 <= reg_rd;
    p2 <= p1;
  end
  assign reg_rdata = p2 ? rd_value : 16'hDEAD;

  // Bus and response event monitor.
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= reg_addr;
      wr_data <= reg_wdata;
    end
    if (reg_rd) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= reg_addr;
    end
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (rsp_req && !rsp_req_prev) tx_cnt <= tx_cnt + 1;
    rsp_req_prev <= rsp_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    cmd_data = b;
    cmd_req  = 1'b1;
    n = 0;
    while (cmd_ack !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("cmd_ack_rise", 32'(cmd_ack), 32'd1);
    cmd_req = 1'b0;
    n = 0;
    while (cmd_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ack_fall", 32'(cmd_ack), 32'd0);
    @(negedge clk);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (rsp_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("rsp_req_rise", 32'(rsp_req), 32'd1);
    chk(tag, 32'(rsp_data), 32'(exp));
    rsp_ack = 1'b1;
    @(negedge clk);
    chk("rsp_req_drop", 32'(rsp_req), 32'd0);
    repeat (2) @(negedge clk);
    chk("rsp_req_gap", 32'(rsp_req), 32'd0);
    rsp_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ack", 32'(cmd_ack), 32'd0);
    chk("rst_rsp_req", 32'(rsp_req), 32'd0);
    chk("rst_strobes", 32'({reg_wr, reg_rd, cmd_err}), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Write 0x1234 <= 0xABCD
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef FT232R_CMD_BRIDGE_WR_ACK_EN
    recv_byte("wr_ack_byte", 8'h06);
`endif
    repeat (5) @(negedge clk);
    chk("wr_count", 32'(wr_cnt), 32'd1);
    chk("wr_addr", 32'(wr_addr), 32'h1234);
    chk("wr_data", 32'(wr_data), 32'hABCD);
    chk("wr_no_read", 32'(rd_cnt), 32'd0);
`ifdef FT232R_CMD_BRIDGE_WR_ACK_EN
    chk("wr_tx_count", 32'(tx_cnt), 32'd1);
`else
    chk("wr_tx_count", 32'(tx_cnt), 32'd0);
`endif
    chk("addr_held", 32'(reg_addr), 32'h1234);

    // Read 0x0010 -> 0xBEEF
    rd_value = 16'hBEEF;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    recv_byte("rd_hi", 8'hBE);
    recv_byte("rd_lo", 8'hEF);
    chk("rd_count", 32'(rd_cnt), 32'd1);
    chk("rd_addr", 32'(rd_addr), 32'h0010);

    // Bad opcode then a normal read
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    chk("bad_op_err", 32'(err_cnt), 32'd1);
    chk("bad_op_no_strobe", 32'(wr_cnt + rd_cnt), 32'd2);
    rd_value = 16'h1357;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    recv_byte("rd2_hi", 8'h13);
    recv_byte("rd2_lo", 8'h57);
    chk("rd2_addr", 32'(rd_addr), 32'h0020);

    // Timeout after 57,12
    send_byte(8'h57); send_byte(8'h12);
    repeat (90) @(negedge clk);
    chk("to_not_early", 32'(err_cnt), 32'd1);
    repeat (15) @(negedge clk);
    chk("to_err", 32'(err_cnt), 32'd2);
    chk("to_no_write", 32'(wr_cnt), 32'd1);
    rd_value = 16'h0102;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    recv_byte("rd3_hi", 8'h01);
    recv_byte("rd3_lo", 8'h02);
    chk("rd3_addr", 32'(rd_addr), 32'h0001);
    chk("rd3_count", 32'(rd_cnt), 32'd3);

    // Reset while the first response byte is pending
    rd_value = 16'h7788;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
    begin
      int n;
      n = 0;
      while (rsp_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    end
    chk("pre_rst_rsp_req", 32'(rsp_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp_req", 32'(rsp_req), 32'd0);
    chk("mid_rst_cmd_ack", 32'(cmd_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h57); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h12); send_byte(8'h34);
`ifdef FT232R_CMD_BRIDGE_WR_ACK_EN
    recv_byte("wr2_ack_byte", 8'h06);
`endif
    repeat (5) @(negedge clk);
    chk("wr2_count", 32'(wr_cnt), 32'd2);
    chk("wr2_addr", 32'(wr_addr), 32'hAA55);
    chk("wr2_data", 32'(wr_data), 32'h1234);

    // Byte offered during a response is held off until IDLE
    rd_value = 16'hCAFE;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h30);
    begin
      int n;
      n = 0;
      while (rsp_req !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    end
    cmd_data = 8'h52;
    cmd_req  = 1'b1;
    repeat (4) @(negedge clk);
    chk("b2b_held_off", 32'(cmd_ack), 32'd0);
    recv_byte("b2b_hi", 8'hCA);
    chk("b2b_still_held", 32'(cmd_ack), 32'd0);
    recv_byte("b2b_lo", 8'hFE);
    begin
      int n;
      n = 0;
      while (cmd_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    end
    chk("b2b_accepted", 32'(cmd_ack), 32'd1);
    cmd_req = 1'b0;
    repeat (2) @(negedge clk);
    rd_value = 16'h4242;
    send_byte(8'h00); send_byte(8'h31);
    recv_byte("b2b2_hi", 8'h42);
    recv_byte("b2b2_lo", 8'h42);
    chk("b2b_addr", 32'(rd_addr), 32'h0031);
    chk("b2b_rd_count", 32'(rd_cnt), 32'd6);
    chk("b2b_err_count", 32'(err_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft232r_cmd_bridge.md
Name: ft232r_cmd_bridge

Overview:
- Command decoder directly downstream of the FT232R UART adapter.
- Consumes received bytes over the 4-phase cmd_req/cmd_ack handshake and parses them into 16-bit register writes and reads on a simple local register bus.
- Returns read data (high byte first) over the rsp_req/rsp_ack handshake, for serialisation back to the host.

Parameters:
- P_RD_LATENCY, 2: cycles from the reg_rd pulse to valid reg_rdata. Legal range 1..15.
- P_TIMEOUT_CYCLES, 1_250_000: maximum idle gap between bytes of one command (10 ms at 125 MHz). Legal range ≥ 2.
- P_OP_WR, 8'h57: write opcode ('W').
- P_OP_RD, 8'h52: read opcode ('R').

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_req  in  1  adapter has a received byte on cmd_data
- cmd_ack  out  1  bridge has captured cmd_data
- cmd_data  in  8  received byte
- rsp_req  out  1  request the adapter to transmit rsp_data
- rsp_ack  in  1  adapter finished transmitting the byte
- rsp_data  out  8  byte to transmit
- reg_addr  out  16  register address
- reg_wdata  out  16  register write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  16  register read data
- cmd_err  out  1  one-cycle pulse on a bad opcode or a timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0. Reset mid-command or mid-response aborts it immediately; the partial command is discarded and the next cycle has rsp_req=0 and cmd_ack=0.
- Protocol:
  - Write: P_OP_WR, ADDR_H, ADDR_L, DATA_H, DATA_L. No response unless the optional feature is enabled.
  - Read: P_OP_RD, ADDR_H, ADDR_L. Response is 2 bytes: rdata[15:8], then rdata[7:0].
- Byte receive (4-phase):
  - Only in the byte-receiving states (IDLE, ADDR_H, ADDR_L, DATA_H, DATA_L).
  - Accept when cmd_req=1 and cmd_ack=0: latch cmd_data and set cmd_ack=1 next cycle.
  - Clear cmd_ack=0 the first cycle cmd_req=0, in any state.
  - Only one byte is accepted per cmd_req high phase.
  - In non-receiving states cmd_req is left pending and accepted on return to IDLE.
- FSM:
  - IDLE: byte == P_OP_WR → ADDR_H (write flag set). Byte == P_OP_RD → ADDR_H (write flag clear). Any other byte → cmd_err pulse, stay in IDLE.
  - ADDR_H → ADDR_L: latch reg_addr[15:8].
  - ADDR_L: latch reg_addr[7:0]. Write flag set → DATA_H; clear → READ.
  - DATA_H → DATA_L: latch reg_wdata[15:8].
  - DATA_L: latch reg_wdata[7:0] → WRITE.
  - WRITE: reg_wr=1 for exactly 1 cycle → IDLE.
  - READ: reg_rd=1 for 1 cycle → RD_WAIT.
  - RD_WAIT: count P_RD_LATENCY cycles after the reg_rd cycle, sample reg_rdata into a 16-bit holding register → TX_H.
  - TX_H / TX_L: rsp_data = hold[15:8] / hold[7:0]; rsp_req=1 until the first cycle rsp_ack=1, then rsp_req=0 → TX_GAP.
  - TX_GAP: wait for rsp_ack=0 (minimum 1 cycle with rsp_req=0), then TX_H→TX_L or TX_L→IDLE.
- Register bus outputs: reg_addr and reg_wdata are stable during the strobe cycle and hold their value until the next latch.
- Timeout:
  - The counter runs in ADDR_H..DATA_L and clears on each accepted byte.
  - When it reaches P_TIMEOUT_CYCLES-1: → IDLE, cmd_err pulse, no register access.
  - No timeout in IDLE, RD_WAIT, or the TX states.
- Simultaneous events: a timeout and a byte accept in the same cycle — the accept wins.
- rsp_ack=1 while rsp_req=0 is ignored outside TX_GAP.

Optional Feature:
- Macro: FT232R_CMD_BRIDGE_WR_ACK_EN
- Defined: after the WRITE strobe the FSM goes to TX_L with hold[7:0]=8'h06 and transmits that single ACK byte before returning to IDLE. The byte uses the same handshake rules.
- Undefined: WRITE → IDLE, no bytes transmitted; the holding register and TX path are used by reads only.

Test Plan:
- Write: bytes 57,12,34,AB,CD → single reg_wr cycle with reg_addr=16'h1234, reg_wdata=16'hABCD. rsp_req stays 0 (macro undefined) or one byte 8'h06 is sent (macro defined).
- Read: bytes 52,00,10 with reg_rdata=16'hBEEF, P_RD_LATENCY=2 → reg_rd pulse with reg_addr=16'h0010, then rsp_data=8'hBE then 8'hEF. rsp_req drops the cycle after rsp_ack rises, and the second byte starts only after rsp_ack returns low.
- Bad opcode: byte 8'h00 → one cmd_err pulse, cmd_ack handshake still completes, no strobe. A following read command then executes normally.
- Timeout: P_TIMEOUT_CYCLES=100, send 57,12 then stall 100 cycles → cmd_err pulse, FSM back in IDLE. Then 52,00,01 → reg_rd with reg_addr=16'h0001.
- Reset mid-response: assert rst while rsp_req=1 in TX_H → next cycle rsp_req=0, cmd_ack=0, FSM in IDLE. A subsequent write executes correctly.
- Back-to-back: cmd_req re-asserted while in READ/TX states → byte not acked until IDLE, then accepted exactly once.
